// File: rtl/poci_keys_irq_if.sv
// POCI peripheral bus: one bundle of request/response signals shared by
// the bus master and a peripheral slave.
interface if_poci #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/poci_keys_irq.sv
// POCI key/switch peripheral: synchronised and debounced inputs, sticky
// write-1-to-clear edge events and a maskable level interrupt.
module poci_keys_irq #(
  parameter int unsigned NKEY            = 4,
  parameter int unsigned NSW             = 10,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic            pclk,
  input  logic            preset,
  if_poci.slave           bus,
  input  logic [NKEY-1:0] key,
  input  logic [NSW-1:0]  sw,
  output logic            irq
);

  localparam int unsigned NIN = NKEY + NSW;
  localparam int unsigned CW  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Keys and switches share one pipeline: switches occupy the upper bits.
  localparam logic [NIN-1:0] IDLE     = {{NSW{1'b0}}, {NKEY{KEY_ACTIVE_LOW}}};

  localparam logic [11:0] ADDR_KEY     = 12'h000;
  localparam logic [11:0] ADDR_SW      = 12'h004;
  localparam logic [11:0] ADDR_KEY_EVT = 12'h008;
  localparam logic [11:0] ADDR_SW_EVT  = 12'h00C;
  localparam logic [11:0] ADDR_IRQ_EN  = 12'h010;

  logic [SYNC_STAGES-1:0][NIN-1:0] sync_q, sync_d;
  logic [NIN-1:0]                  db_q, db_d;
  logic [NIN-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [NKEY-1:0]                 key_evt_q, key_evt_d;
  logic [NSW-1:0]                  sw_evt_q, sw_evt_d;
  logic [1:0]                      irq_en_q, irq_en_d;
  logic                            irq_q, irq_d;

  logic [NIN-1:0]  synced_c;
  logic [NIN-1:0]  chg_c;
  logic [NKEY-1:0] key_press_c;
  logic [11:0]     addr_c;
  logic            addr_ok_c;
  logic            wr_c;
  logic            rd_c;
  logic [31:0]     rdata_c;
  logic            unused_ok_c;

  assign synced_c    = sync_q[SYNC_STAGES-1];
  assign addr_c      = bus.paddr[11:0];
  assign unused_ok_c = ^{bus.pwdata, bus.paddr};

  // Debounce: a bit changes only after CNT_LAST+1 consecutive differing cycles.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sw, key};
    db_d   = db_q;
    cnt_d  = '0;
    chg_c  = '0;
    for (int i = 0; i < int'(NIN); i++) begin
      if (synced_c[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i]  = synced_c[i];
          chg_c[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    key_press_c = chg_c[NKEY-1:0] &
                  (KEY_ACTIVE_LOW ? ~db_d[NKEY-1:0] : db_d[NKEY-1:0]);
  end

  // Address decode and register read mux.
  always_comb begin
    addr_ok_c = 1'b0;
    rdata_c   = '0;
    case (addr_c)
      ADDR_KEY:     begin addr_ok_c = 1'b1; rdata_c = 32'(db_q[NKEY-1:0]);   end
      ADDR_SW:      begin addr_ok_c = 1'b1; rdata_c = 32'(db_q[NIN-1:NKEY]); end
      ADDR_KEY_EVT: begin addr_ok_c = 1'b1; rdata_c = 32'(key_evt_q);        end
      ADDR_SW_EVT:  begin addr_ok_c = 1'b1; rdata_c = 32'(sw_evt_q);         end
      ADDR_IRQ_EN:  begin addr_ok_c = 1'b1; rdata_c = 32'(irq_en_q);         end
      default:      begin addr_ok_c = 1'b0; rdata_c = '0;                    end
    endcase
    wr_c = bus.psel & bus.penable & bus.pwrite & addr_ok_c;
    rd_c = bus.psel & ~bus.pwrite & addr_ok_c;
    bus.prdata  = rd_c ? rdata_c : '0;
    bus.pslverr = bus.psel & bus.penable & ~addr_ok_c;
    bus.pready  = 1'b1;
  end

  // Event and enable registers; a new event beats a same-cycle clear.
  always_comb begin
    key_evt_d = key_evt_q;
    sw_evt_d  = sw_evt_q;
    irq_en_d  = irq_en_q;
    if (wr_c && (addr_c == ADDR_KEY_EVT)) begin
      key_evt_d = key_evt_q & ~bus.pwdata[NKEY-1:0];
    end
    if (wr_c && (addr_c == ADDR_SW_EVT)) begin
      sw_evt_d = sw_evt_q & ~bus.pwdata[NSW-1:0];
    end
    if (wr_c && (addr_c == ADDR_IRQ_EN)) begin
      irq_en_d = bus.pwdata[1:0];
    end
    key_evt_d = key_evt_d | key_press_c;
    sw_evt_d  = sw_evt_d | chg_c[NIN-1:NKEY];
    irq_d     = (irq_en_q[0] & (|key_evt_q)) | (irq_en_q[1] & (|sw_evt_q));
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      sync_q    <= {SYNC_STAGES{IDLE}};
      db_q      <= IDLE;
      cnt_q     <= '0;
      key_evt_q <= '0;
      sw_evt_q  <= '0;
      irq_en_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      key_evt_q <= key_evt_d;
      sw_evt_q  <= sw_evt_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_poci_keys_irq.sv
// Directed bench for poci_keys_irq: stimulus queues expected bus responses,
// a negedge monitor pops and compares them on every access phase.
module tb_poci_keys_irq;

  logic        pclk = 1'b0;
  logic        preset;
  logic [3:0]  key;
  logic [9:0]  sw;
  logic        irq;

  if_poci bus ();

  poci_keys_irq #(
    .NKEY            (4),
    .NSW             (10),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (8),
    .KEY_ACTIVE_LOW  (1'b1)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus),
    .key    (key),
    .sw     (sw),
    .irq    (irq)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        irq;
    logic [63:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input logic [63:0] tag, input logic [63:0] fld,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %0s %0s: got 0x%08h expected 0x%08h at %0t", tag, fld, act, exp, $time);
    end
  endtask

  // Monitor: every access phase consumes one expectation; idle bus must read 0.
  always @(negedge pclk) begin
    exp_t x;
    if (!preset) begin
      if (bus.psel && bus.penable) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_xfer: got access with empty queue at %0t", $time);
        end else begin
          x = exp_q.pop_front();
          chk(x.tag, "prdata", bus.prdata, x.rdata);
          chk(x.tag, "pslverr", 32'(bus.pslverr), 32'(x.err));
          chk(x.tag, "irq", 32'(irq), 32'(x.irq));
          chk(x.tag, "pready", 32'(bus.pready), 32'd1);
        end
      end else if (!bus.psel) begin
        chk("idle", "prdata", bus.prdata, 32'd0);
        chk("idle", "pslverr", 32'(bus.pslverr), 32'd0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic e, input logic i, input logic [63:0] t);
    exp_t x;
    x.rdata = d;
    x.err   = e;
    x.irq   = i;
    x.tag   = t;
    exp_q.push_back(x);
  endtask

  // Read: setup cycle, then one access cycle checked by the monitor.
  task automatic rd(input logic [11:0] a, input logic [31:0] d, input logic e,
                    input logic i, input logic [63:0] t);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 32'(a);
    cyc(1);
    bus.penable = 1'b1;
    push(d, e, i, t);
    cyc(1);
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  // Read held for two access cycles, pinning the exact cycle a value changes.
  task automatic rd_hold(input logic [11:0] a, input logic [31:0] d0, input logic [31:0] d1,
                         input logic i, input logic [63:0] t);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 32'(a);
    cyc(1);
    bus.penable = 1'b1;
    push(d0, 1'b0, i, t);
    cyc(1);
    push(d1, 1'b0, i, t);
    cyc(1);
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic e,
                    input logic i, input logic [63:0] t);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 32'(a); bus.pwdata = d;
    cyc(1);
    bus.penable = 1'b1;
    push(32'd0, e, i, t);
    cyc(1);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  initial begin
    preset = 1'b1;
    key = 4'hF;
    sw  = 10'h000;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0;  bus.pwdata = '0;
    cyc(3);
    preset = 1'b0;
    cyc(2);

    // Reset values
    rd(12'h000, 32'h0000_000F, 1'b0, 1'b0, "R_KEY");
    rd(12'h004, 32'h0000_0000, 1'b0, 1'b0, "R_SW");
    rd(12'h008, 32'h0000_0000, 1'b0, 1'b0, "R_KEVT");
    rd(12'h00C, 32'h0000_0000, 1'b0, 1'b0, "R_SEVT");
    rd(12'h010, 32'h0000_0000, 1'b0, 1'b0, "R_IRQEN");

    // 7-cycle glitch on key[1] is filtered
    key = 4'hD;
    cyc(7);
    key = 4'hF;
    cyc(5);
    rd(12'h000, 32'h0000_000F, 1'b0, 1'b0, "GL_KEY");
    rd(12'h008, 32'h0000_0000, 1'b0, 1'b0, "GL_KEVT");

    // Clean press: debounced level flips exactly 10 edges after the step
    key = 4'hD;
    cyc(8);
    rd_hold(12'h000, 32'h0000_000F, 32'h0000_000D, 1'b0, "PR_KEY");
    rd(12'h008, 32'h0000_0002, 1'b0, 1'b0, "PR_KEVT");
    key = 4'hF;
    cyc(15);
    rd(12'h000, 32'h0000_000F, 1'b0, 1'b0, "RL_KEY");
    rd(12'h008, 32'h0000_0002, 1'b0, 1'b0, "RL_KEVT");

    // Enable with pending event, then W1C clears the interrupt
    wr(12'h010, 32'h0000_0001, 1'b0, 1'b0, "W_EN1");
    rd(12'h010, 32'h0000_0001, 1'b0, 1'b1, "EN1_IRQ");
    wr(12'h008, 32'h0000_0002, 1'b0, 1'b1, "W1C_K");
    rd(12'h008, 32'h0000_0000, 1'b0, 1'b0, "W1C_IRQ");

    // Switch 9 up then down
    sw = 10'h200;
    cyc(14);
    rd(12'h004, 32'h0000_0200, 1'b0, 1'b0, "SW_UP");
    cyc(4);
    sw = 10'h000;
    cyc(14);
    rd(12'h004, 32'h0000_0000, 1'b0, 1'b0, "SW_DN");
    rd(12'h00C, 32'h0000_0200, 1'b0, 1'b0, "SW_EVT");

    // Press of key[0] lands on the same edge as a W1C of bit 0
    key = 4'hE;
    cyc(8);
    wr(12'h008, 32'h0000_0001, 1'b0, 1'b0, "RACE_W");
    rd(12'h008, 32'h0000_0001, 1'b0, 1'b1, "RACE_R");
    rd(12'h000, 32'h0000_000E, 1'b0, 1'b1, "RACE_KEY");
    key = 4'hF;
    cyc(15);

    // Switch-event interrupt path
    wr(12'h010, 32'h0000_0002, 1'b0, 1'b1, "W_EN2");
    rd(12'h010, 32'h0000_0002, 1'b0, 1'b1, "EN2");
    wr(12'h008, 32'h0000_0001, 1'b0, 1'b1, "CLR_K0");
    rd(12'h008, 32'h0000_0000, 1'b0, 1'b1, "KEVT_0");
    wr(12'h00C, 32'h0000_0200, 1'b0, 1'b1, "CLR_SW9");
    rd(12'h00C, 32'h0000_0000, 1'b0, 1'b0, "SEVT_0");

    // Upper write bits ignored; bad offset errors without side effects
    wr(12'h010, 32'hFFFF_FFFD, 1'b0, 1'b0, "W_ENMSK");
    rd(12'h010, 32'h0000_0001, 1'b0, 1'b0, "ENMSK");
    rd(12'h014, 32'h0000_0000, 1'b1, 1'b0, "BAD_RD");
    wr(12'h014, 32'hFFFF_FFFF, 1'b1, 1'b0, "BAD_WR");
    wr(12'h000, 32'h0000_0000, 1'b0, 1'b0, "W_KEY");
    rd(12'h010, 32'h0000_0001, 1'b0, 1'b0, "BAD_EN");
    rd(12'h008, 32'h0000_0000, 1'b0, 1'b0, "BAD_KEV");
    rd(12'h00C, 32'h0000_0000, 1'b0, 1'b0, "BAD_SEV");
    rd(12'h000, 32'h0000_000F, 1'b0, 1'b0, "BAD_KEY");
    rd(12'h004, 32'h0000_0000, 1'b0, 1'b0, "BAD_SW");

    // Reset in the middle of a debounce restarts the count
    key = 4'hD;
    cyc(5);
    preset = 1'b1;
    cyc(2);
    preset = 1'b0;
    cyc(8);
    rd_hold(12'h000, 32'h0000_000F, 32'h0000_000D, 1'b0, "RST_KEY");
    rd(12'h008, 32'h0000_0002, 1'b0, 1'b0, "RST_KEV");
    rd(12'h010, 32'h0000_0000, 1'b0, 1'b0, "RST_EN");
    key = 4'hF;
    cyc(4);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc(1);
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
